abs_val_arbiter: RTL
====================

Name: abs_val_arbiter

Overview:
- Shares one parallel-prefix absolute-value datapath (AbsVal, instantiated internally) between NumReq requesters.
- Round-robin arbitration, valid/ready handshakes on every requester and on the single response port.
- Registered result is returned with the requester ID and an overflow flag.
- Sits between several lane controllers and a single |A| unit, so the datapath is not replicated per lane.

Parameters:
- Width, 8, operand/result word width; must be >= 2.
- NumReq, 4, number of requesters; must be >= 2.
- Speed, lau_pkg::FAST, passed unchanged to the internal AbsVal instance.
- IdWidth, $clog2(NumReq), derived width of the response ID; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NumReq  per-requester operand valid.
- req_ready_o  output  NumReq  per-requester accept; at most one bit high per cycle.
- req_data_i  input  NumReq*Width  packed operands; requester i occupies bits [i*Width +: Width].
- rsp_valid_o  output  1  result register holds a valid result.
- rsp_ready_i  input  1  downstream accepts the result.
- rsp_data_o  output  Width  |operand| of the accepted request.
- rsp_id_o  output  IdWidth  index of the requester that produced rsp_data_o.
- rsp_ovf_o  output  1  operand was the most negative value (1 followed by Width-1 zeros).

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_ovf_o=0.
  - Round-robin pointer ptr=0; req_ready_o=0 while rst_ni=0.
- Output slot: one-entry register. can_accept = !rsp_valid_o || rsp_ready_i; same-cycle pop+push is allowed.
- Arbitration (combinational each cycle):
  - grant = first i with req_valid_i[i]=1, searching ptr, ptr+1, ..., wrapping modulo NumReq.
  - req_ready_o[grant]=can_accept; all other bits 0; all 0 if no requester is valid.
- Acceptance: req_valid_i[g] && req_ready_o[g] at an edge. On that edge:
  - rsp_data_o <= AbsVal(req_data_i[g]).
  - rsp_id_o <= g; rsp_ovf_o <= (operand == 1 followed by Width-1 zeros); rsp_valid_o <= 1.
  - ptr <= (g+1) mod NumReq; wraps from NumReq-1 to 0.
- Pop without push: rsp_valid_o && rsp_ready_i && no acceptance -> rsp_valid_o <= 0; data/id/ovf hold their last values.
- Stall: rsp_valid_o && !rsp_ready_i -> rsp_* stable, all req_ready_o = 0, ptr unchanged.
- Latency: one cycle from acceptance to rsp_valid_o. Throughput: one result per cycle under rsp_ready_i=1.
- Requester protocol: once asserted, valid and data are held until ready; no combinational path req_ready_o -> req_valid_i is required. ptr advances only on acceptance, so a waiting requester is granted within NumReq accepted transfers.
- Arithmetic:
  - Non-negative operand -> itself. Negative operand -> two's-complement negation.
  - Most negative operand -> most negative pattern, ovf=1.
- Reset mid-transfer: pending result and pointer are discarded immediately; no partial response after release.

Optional Feature:
- Macro ABS_VAL_ARBITER_SATURATE_EN.
- Defined: a most-negative operand yields rsp_data_o = 0 followed by Width-1 ones (max positive), with rsp_ovf_o=1.
- Undefined: rsp_data_o = wrapped two's-complement result (1 followed by Width-1 zeros), with rsp_ovf_o=1.
- All other behaviour is identical in both builds.

Test Plan (Width=8, NumReq=4):
- Reset: assert rst_ni=0 asynchronously mid-cycle -> rsp_valid_o/data/id/ovf = 0 and req_ready_o = 0000 immediately; ptr=0 after release.
- Single request: req_valid_i=0010, requester 1 data 0xF6, rsp_ready_i=1 -> req_ready_o=0010; next cycle rsp_valid_o=1, rsp_data_o=0x0A, rsp_id_o=1, rsp_ovf_o=0.
- Fairness: all four valid continuously with data 0x01,0xFF,0x7F,0x81, rsp_ready_i=1 -> rsp_id_o sequence 0,1,2,3,0 on consecutive cycles, all data = 0x01,0x01,0x7F,0x7F.
- Backpressure: result held with rsp_ready_i=0 for 3 cycles -> req_ready_o=0000, rsp_* stable; raise rsp_ready_i -> pop and next push in the same cycle, rsp_valid_o stays 1.
- Overflow: requester 3 sends 0x80 -> rsp_data_o=0x80, rsp_ovf_o=1 (0x7F, rsp_ovf_o=1 with ABS_VAL_ARBITER_SATURATE_EN); 0x00 -> rsp_data_o=0x00, rsp_ovf_o=0.
- Reset mid-operation: pulse rst_ni low while rsp_valid_o=1 and ptr=2 -> rsp_valid_o drops at once; after release, with all valid, first grant is requester 0.

Source files
------------

// File: rtl/lau_pkg.sv
// Shared definitions for the |A| datapath.
//   speed_e : implementation choice for the prefix network inside AbsVal.
//             SMALL = serial (ripple) prefix OR, FAST = log-depth prefix OR.
package lau_pkg;

  typedef enum logic {
    SMALL,
    FAST
  } speed_e;

endpackage

// File: rtl/AbsVal.sv
// Combinational two's-complement absolute value built on a prefix-OR network.
// For a negative operand, bit i of -a equals a[i] XOR (|a[i-1:0]), so only an
// exclusive prefix OR is needed instead of a full adder.
// The most negative value maps onto itself (wrapped result).
// Ports:
//   a_i   in  Width  signed operand
//   abs_o out Width  |a_i| (wrapped for the most negative value)
module AbsVal #(
  parameter int unsigned     Width = 8,
  parameter lau_pkg::speed_e Speed = lau_pkg::FAST
) (
  input  logic [Width-1:0] a_i,
  output logic [Width-1:0] abs_o
);

  localparam int unsigned Levels = $clog2(Width);

  // w_prefix[i] = |a_i[i:0]
  logic [Width-1:0] w_prefix;
  logic [Width-1:0] w_excl;

  if (Speed == lau_pkg::FAST) begin : g_fast
    // Log-depth prefix: each level ORs in the value 2^l positions below.
    always_comb begin
      w_prefix = a_i;
      for (int l = 0; l < Levels; l++) begin
        w_prefix = w_prefix | (w_prefix << (1 << l));
      end
    end
  end else begin : g_small
    always_comb begin
      w_prefix = a_i;
      for (int i = 1; i < Width; i++) begin
        w_prefix[i] = w_prefix[i-1] | a_i[i];
      end
    end
  end

  assign w_excl = {w_prefix[Width-2:0], 1'b0};
  assign abs_o  = a_i[Width-1] ? (a_i ^ w_excl) : a_i;

endmodule

// File: rtl/abs_val_arbiter.sv
// Round-robin arbiter sharing one AbsVal datapath between NumReq requesters.
// The winner's |operand| is registered in a one-entry output slot together
// with its requester index and an overflow flag (operand was the most
// negative value). The slot may be popped and refilled in the same cycle.
// Optional build macro: ABS_VAL_ARBITER_SATURATE_EN -- when defined, a most
// negative operand returns the maximum positive value instead of wrapping.
// Ports:
//   clk_i        in   1             clock, rising edge
//   rst_ni       in   1             asynchronous active-low reset
//   req_valid_i  in   NumReq        per-requester operand valid
//   req_ready_o  out  NumReq        per-requester accept (one-hot or zero)
//   req_data_i   in   NumReq*Width  operands, requester i at [i*Width +: Width]
//   rsp_valid_o  out  1             output slot holds a result
//   rsp_ready_i  in   1             downstream accepts the result
//   rsp_data_o   out  Width         |operand|
//   rsp_id_o     out  IdWidth       index of the producing requester
//   rsp_ovf_o    out  1             operand was the most negative value
module abs_val_arbiter #(
  parameter int unsigned     Width   = 8,
  parameter int unsigned     NumReq  = 4,
  parameter lau_pkg::speed_e Speed   = lau_pkg::FAST,
  localparam int unsigned    IdWidth = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Width-1:0]        rsp_data_o,
  output logic [IdWidth-1:0]      rsp_id_o,
  output logic                    rsp_ovf_o
);

  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  logic [IdWidth-1:0] r_ptr;
  logic               r_rsp_valid;
  logic [Width-1:0]   r_rsp_data;
  logic [IdWidth-1:0] r_rsp_id;
  logic               r_rsp_ovf;

  logic               w_can_accept;
  logic               w_found;
  logic [IdWidth-1:0] w_grant;
  logic               w_accept;
  logic [Width-1:0]   w_operand;
  logic [Width-1:0]   w_abs;
  logic               w_ovf;
  logic [Width-1:0]   w_result;
  logic [IdWidth-1:0] w_ptr_next;

  assign w_can_accept = !r_rsp_valid || rsp_ready_i;

  // First valid requester at or after the pointer, wrapping modulo NumReq.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (int'(r_ptr) + k) % NumReq;
      if (!w_found && req_valid_i[idx]) begin
        w_found = 1'b1;
        w_grant = IdWidth'(idx);
      end
    end
  end

  // Gated with rst_ni so no requester sees ready while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (w_found && rst_ni) begin
      req_ready_o[w_grant] = w_can_accept;
    end
  end

  assign w_accept  = w_found && w_can_accept;
  assign w_operand = req_data_i[w_grant*Width +: Width];
  assign w_ovf     = (w_operand == MinNeg);

  AbsVal #(
    .Width (Width),
    .Speed (Speed)
  ) u_abs_val (
    .a_i   (w_operand),
    .abs_o (w_abs)
  );

`ifdef ABS_VAL_ARBITER_SATURATE_EN
  assign w_result = w_ovf ? {1'b0, {(Width-1){1'b1}}} : w_abs;
`else
  assign w_result = w_abs;
`endif

  assign w_ptr_next = (w_grant == IdWidth'(NumReq - 1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_next;
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_result;
      r_rsp_id    <= w_grant;
      r_rsp_ovf   <= w_ovf;
    end else if (rsp_ready_i) begin
      // Pop without refill: payload holds its last value.
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_ovf_o   = r_rsp_ovf;

endmodule
